load_wakeup_spec_ctrl: RTL

Controls speculative wake-up for integer-queue consumers of loads. It sits between the load pipeline and the integer issue-side replay buffer. For each issued load it predicts a D-cache hit and, if a hit is predicted, broadcasts an early wake-up. It then checks the actual hit/miss result `LOAD_LAT` cycles after issue and drives the replay-control signals (`load_wake_up_predict_failed`, `load_wake_up_failed_stall`, `load_depend_replay`) that the replay buffer consumes.

---
 rtl/load_wakeup_spec_ctrl_pkg.sv | 41 ++++
 rtl/load_wakeup_spec_ctrl_hit_predictor.sv | 28 ++
 rtl/load_wakeup_spec_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/load_wakeup_spec_ctrl_pkg.sv
// Shared types for the load speculative wake-up controller.
// ROB tags carry a wrap bit in the MSB for age comparison.
package load_wakeup_spec_ctrl_pkg;

  localparam int ROB_W        = 6;
  localparam int PREG_W       = 7;
  localparam int LOAD_LAT_DEF = 2;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob_tag;
  } branch_flush_t;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob_tag;
    logic [PREG_W-1:0] pdst;
    logic              pred_hit;
  } load_spec_entry_t;

  typedef enum logic {
    LW_RUN   = 1'b0,
    LW_STALL = 1'b1
  } lw_state_e;

  // True when tag is younger than the mispredicted branch.
  function automatic logic IsBrROBKill(
    input branch_flush_t    f,
    input logic [ROB_W-1:0] tag
  );
    logic same_wrap;
    logic kill;
    same_wrap = (f.rob_tag[ROB_W-1] == tag[ROB_W-1]);
    if (same_wrap)
      kill = f.rob_tag[ROB_W-2:0] < tag[ROB_W-2:0];
    else
      kill = f.rob_tag[ROB_W-2:0] > tag[ROB_W-2:0];
    return f.valid && kill;
  endfunction

endpackage

// File: rtl/load_wakeup_spec_ctrl_hit_predictor.sv
// Saturating hit/miss counter; MSB is the hit prediction.
// Resets to all ones (strongly predict hit).
module load_hit_predictor #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic upd_hit,
  input  logic upd_miss,
  output logic hit_predict
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= CNT_MAX;
    else if (upd_hit && cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
    else if (upd_miss && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign hit_predict = cnt[CNT_W-1];

endmodule

// File: rtl/load_wakeup_spec_ctrl.sv
// Speculative load wake-up: hit prediction, shadow pipe,
// resolve and miss-stall FSM driving the replay buffer.
module load_wakeup_spec_ctrl
  import load_wakeup_spec_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  branch_flush_t     recovery_flush_BCAST,
  input  logic              load_issue_valid,
  input  logic [ROB_W-1:0]  load_issue_rob_tag,
  input  logic [PREG_W-1:0] load_issue_pdst,
  input  logic              dcache_resp_valid,
  input  logic              dcache_resp_hit,
  input  logic [ROB_W-1:0]  dcache_resp_rob_tag,
  input  logic              refill_done,
  output logic              spec_wakeup_valid,
  output logic [PREG_W-1:0] spec_wakeup_pdst,
  output logic              real_wakeup_valid,
  output logic [PREG_W-1:0] real_wakeup_pdst,
  output logic              load_wake_up_predict_failed,
  output logic              load_wake_up_failed_stall,
  output logic              load_depend_replay,
  output logic              hit_predict
);

  load_spec_entry_t  sh_q [LOAD_LAT];
  load_spec_entry_t  sh_d [LOAD_LAT];
  load_spec_entry_t  tail;
  load_spec_entry_t  new_e;

  lw_state_e         state_q;
  lw_state_e         state_d;
  logic [ROB_W-1:0]  lat_tag_q;
  logic [ROB_W-1:0]  lat_tag_d;
  logic [PREG_W-1:0] lat_pdst_q;
  logic [PREG_W-1:0] lat_pdst_d;
  logic              lat_pred_q;
  logic              lat_pred_d;

  logic              tail_live;
  logic              resp_hit;
  logic              res_hit;
  logic              res_miss;

  logic              spec_v_d;
  logic [PREG_W-1:0] spec_pdst_d;
  logic              real_v_d;
  logic [PREG_W-1:0] real_pdst_d;
  logic              pf_d;
  logic              rep_d;

  load_hit_predictor #(
    .CNT_W(CNT_W)
  ) u_pred (
    .clk        (clk),
    .rst        (rst),
    .upd_hit    (res_hit),
    .upd_miss   (res_miss),
    .hit_predict(hit_predict)
  );

  // A flushed tail never resolves, so it never trains the counter.
  always_comb begin
    tail      = sh_q[LOAD_LAT-1];
    tail_live = tail.valid
             && !IsBrROBKill(recovery_flush_BCAST, tail.rob_tag);
    resp_hit  = dcache_resp_valid && dcache_resp_hit
             && (dcache_resp_rob_tag == tail.rob_tag);
    res_hit   = tail_live && resp_hit;
    res_miss  = tail_live && !resp_hit;
  end

  always_comb begin
    new_e.valid    = load_issue_valid
                  && (state_q == LW_RUN)
                  && !res_miss
                  && !IsBrROBKill(recovery_flush_BCAST,
                                  load_issue_rob_tag);
    new_e.rob_tag  = load_issue_rob_tag;
    new_e.pdst     = load_issue_pdst;
    new_e.pred_hit = hit_predict;

    sh_d[0] = new_e;
    for (int i = 1; i < LOAD_LAT; i++) begin
      sh_d[i] = sh_q[i-1];
      if (res_miss
          || IsBrROBKill(recovery_flush_BCAST, sh_q[i-1].rob_tag))
        sh_d[i].valid = 1'b0;
    end

    spec_v_d    = new_e.valid && hit_predict;
    spec_pdst_d = spec_v_d ? load_issue_pdst : '0;
  end

  always_comb begin
    state_d     = state_q;
    lat_tag_d   = lat_tag_q;
    lat_pdst_d  = lat_pdst_q;
    lat_pred_d  = lat_pred_q;
    real_v_d    = 1'b0;
    real_pdst_d = '0;
    pf_d        = 1'b0;
    rep_d       = 1'b0;
    unique case (state_q)
      LW_RUN: begin
        if (res_hit && !tail.pred_hit) begin
          real_v_d    = 1'b1;
          real_pdst_d = tail.pdst;
        end
        if (res_miss) begin
          state_d    = LW_STALL;
          lat_tag_d  = tail.rob_tag;
          lat_pdst_d = tail.pdst;
          lat_pred_d = tail.pred_hit;
          pf_d       = tail.pred_hit;
        end
      end
      LW_STALL: begin
        if (IsBrROBKill(recovery_flush_BCAST, lat_tag_q)) begin
          state_d = LW_RUN;
        end else if (refill_done) begin
          state_d     = LW_RUN;
          real_v_d    = 1'b1;
          real_pdst_d = lat_pdst_q;
          rep_d       = lat_pred_q;
        end
      end
      default: state_d = LW_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                     <= LW_RUN;
      lat_tag_q                   <= '0;
      lat_pdst_q                  <= '0;
      lat_pred_q                  <= 1'b0;
      for (int i = 0; i < LOAD_LAT; i++)
        sh_q[i]                   <= '0;
      spec_wakeup_valid           <= 1'b0;
      spec_wakeup_pdst            <= '0;
      real_wakeup_valid           <= 1'b0;
      real_wakeup_pdst            <= '0;
      load_wake_up_predict_failed <= 1'b0;
      load_wake_up_failed_stall   <= 1'b0;
      load_depend_replay          <= 1'b0;
    end else begin
      state_q                     <= state_d;
      lat_tag_q                   <= lat_tag_d;
      lat_pdst_q                  <= lat_pdst_d;
      lat_pred_q                  <= lat_pred_d;
      for (int i = 0; i < LOAD_LAT; i++)
        sh_q[i]                   <= sh_d[i];
      spec_wakeup_valid           <= spec_v_d;
      spec_wakeup_pdst            <= spec_pdst_d;
      real_wakeup_valid           <= real_v_d;
      real_wakeup_pdst            <= real_pdst_d;
      load_wake_up_predict_failed <= pf_d;
      load_wake_up_failed_stall   <= (state_d == LW_STALL);
      load_depend_replay          <= rep_d;
    end
  end

  // Issue queue must hold loads while a miss is outstanding.
  a_no_issue_in_stall: assert property (
    @(posedge clk) disable iff (rst)
    !(load_issue_valid && state_q == LW_STALL)
  );

endmodule
